// File: rtl/dual_counter_sched.sv
// dual_counter_sched: round-robin scheduler sharing one external counter between two requesters.
// Optional watchdog enabled by defining DCS_WATCHDOG_EN.
//
// Ports:
//   CLK      in   1      clock, rising edge
//   nCLR     in   1      synchronous active-low reset
//   REQ      in   2      per-requester request, held until DONE/ERR
//   TGT0     in   WIDTH  requester 0 target, sampled at grant
//   TGT1     in   WIDTH  requester 1 target, sampled at grant
//   CNT_Q    in   WIDTH  counter value read back from the datapath
//   CNT_EN   out  1      counter increment enable (combinational)
//   CNT_CLR  out  1      counter synchronous clear (registered)
//   GNT      out  2      one-hot grant (registered)
//   DONE     out  2      one-cycle completion pulse
//   BUSY     out  1      scheduler not idle
//   ERR      out  1      watchdog abort pulse (0 without DCS_WATCHDOG_EN)
module dual_counter_sched #(
    parameter int WIDTH     = 4,
    parameter int WD_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic [1:0]       REQ,
    input  logic [WIDTH-1:0] TGT0,
    input  logic [WIDTH-1:0] TGT1,
    input  logic [WIDTH-1:0] CNT_Q,
    output logic             CNT_EN,
    output logic             CNT_CLR,
    output logic [1:0]       GNT,
    output logic [1:0]       DONE,
    output logic             BUSY,
    output logic             ERR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]       state;
    logic             last;
    logic             win;
    logic [WIDTH-1:0] tgt_q;
    logic             pick;
    logic             owner_req;
    logic             match;

    // Sole requester wins; on a tie the one not served last wins.
    always_comb begin
        pick = ~last;
        if (REQ == 2'b01) begin
            pick = 1'b0;
        end else if (REQ == 2'b10) begin
            pick = 1'b1;
        end
    end

    assign owner_req = REQ[win];
    assign match     = (CNT_Q == tgt_q);
    assign CNT_EN    = (state == S_RUN) && !match && owner_req;
    assign BUSY      = (state != S_IDLE);

`ifdef DCS_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);

    logic [WDW-1:0] wd_cnt;
    logic           err_q;

    assign ERR = err_q;
`else
    // Constant zero; the parameter is only meaningful with the watchdog.
    assign ERR = (WD_CYCLES < 0);
`endif

    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            win     <= 1'b0;
            tgt_q   <= '0;
            GNT     <= 2'b00;
            DONE    <= 2'b00;
            CNT_CLR <= 1'b0;
`ifdef DCS_WATCHDOG_EN
            wd_cnt  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            DONE    <= 2'b00;
            CNT_CLR <= 1'b0;
`ifdef DCS_WATCHDOG_EN
            err_q   <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (|REQ) begin
                        win     <= pick;
                        last    <= pick;
                        tgt_q   <= pick ? TGT1 : TGT0;
                        GNT     <= pick ? 2'b10 : 2'b01;
                        CNT_CLR <= 1'b1;
                        state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (!owner_req) begin
                        GNT   <= 2'b00;
                        state <= S_IDLE;
                    end else begin
                        state <= S_RUN;
`ifdef DCS_WATCHDOG_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (!owner_req) begin
                        GNT   <= 2'b00;
                        state <= S_IDLE;
                    end else if (match) begin
                        GNT   <= 2'b00;
                        DONE  <= win ? 2'b10 : 2'b01;
                        state <= S_FIN;
                    end
`ifdef DCS_WATCHDOG_EN
                    else if (wd_cnt == WDW'(WD_CYCLES - 1)) begin
                        GNT   <= 2'b00;
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_counter_sched.sv
// tb_dual_counter_sched: directed and randomized checks of dual_counter_sched
// against an ideal counter and a job-level arbitration model.
module tb_dual_counter_sched;

    logic       CLK = 1'b0;
    logic       nCLR;
    logic [1:0] REQ;
    logic [3:0] TGT0;
    logic [3:0] TGT1;
    logic [3:0] q = 4'd0;
    logic       CNT_EN;
    logic       CNT_CLR;
    logic [1:0] GNT;
    logic [1:0] DONE;
    logic       BUSY;
    logic       ERR;
    bit         stuck = 1'b0;

    int nchk = 0;
    int nerr = 0;
    int last_w = 1;

    always #5 CLK = ~CLK;

    dual_counter_sched #(.WIDTH(4), .WD_CYCLES(8)) dut (
        .CLK(CLK), .nCLR(nCLR), .REQ(REQ), .TGT0(TGT0), .TGT1(TGT1),
        .CNT_Q(q), .CNT_EN(CNT_EN), .CNT_CLR(CNT_CLR), .GNT(GNT),
        .DONE(DONE), .BUSY(BUSY), .ERR(ERR)
    );

    // Ideal counter datapath; "stuck" models a disconnected counter.
    always @(posedge CLK) begin
        if (CNT_CLR) q <= 4'd0;
        else if (CNT_EN && !stuck) q <= q + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nedge;
        @(negedge CLK);
    endtask

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return 1 - last_w;
    endfunction

    // One job from arbitration to DONE (or abort after abort_at enables).
    task automatic job(input string tag, input int abort_at,
                       input bit drop, input bit scramble);
        int w, tgt, en, clr;
        bit got, aborted;
        w = pick(REQ);
        tgt = (w == 1) ? int'(TGT1) : int'(TGT0);
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            nedge;
            if (GNT != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " grant_seen"}, got, 1);
        if (!got) return;
        check({tag, " gnt"}, GNT, 1 << w);
        last_w = w;
        if (scramble) begin
            TGT0 = 4'($urandom);
            TGT1 = 4'($urandom);
        end
        en = 0;
        clr = 0;
        got = 1'b0;
        aborted = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (DONE != 2'b00) begin
                got = 1'b1;
                break;
            end
            if (abort_at >= 0 && !CNT_CLR && en == abort_at) begin
                REQ[w] = 1'b0;
                #1;
                check({tag, " en_after_drop"}, CNT_EN, 0);
                aborted = 1'b1;
                break;
            end
            en += int'(CNT_EN);
            clr += int'(CNT_CLR);
            nedge;
        end
        if (aborted) begin
            nedge;
            check({tag, " abort_busy"}, BUSY, 0);
            check({tag, " abort_gnt"}, GNT, 0);
            check({tag, " abort_done"}, DONE, 0);
            check({tag, " abort_q"}, q, abort_at);
            return;
        end
        check({tag, " done_seen"}, got, 1);
        check({tag, " done"}, DONE, 1 << w);
        check({tag, " gnt_at_done"}, GNT, 0);
        check({tag, " en_cycles"}, en, tgt);
        check({tag, " clr_cycles"}, clr, 1);
        check({tag, " q_final"}, q, tgt);
        if (drop) REQ = 2'b00;
        nedge;
        check({tag, " busy_after"}, BUSY, 0);
        check({tag, " done_pulse"}, DONE, 0);
    endtask

    initial begin
        int run, busy_n, err_n, w, tgt, ab;
        bit got;
        nCLR = 1'b0;
        REQ  = 2'b11;
        TGT0 = 4'd0;
        TGT1 = 4'd0;
        for (int i = 0; i < 2; i++) begin
            nedge;
            check("rst gnt", GNT, 0);
            check("rst done", DONE, 0);
            check("rst clr", CNT_CLR, 0);
            check("rst busy", BUSY, 0);
            check("rst err", ERR, 0);
        end
        REQ  = 2'b00;
        nCLR = 1'b1;
        last_w = 1;
        nedge;

        REQ  = 2'b01;
        TGT0 = 4'd5;
        job("t2", -1, 1'b1, 1'b0);

        REQ  = 2'b11;
        TGT0 = 4'd3;
        TGT1 = 4'd2;
        for (int i = 0; i < 4; i++) job("t3", -1, 1'b0, 1'b0);
        REQ = 2'b00;
        nedge;

        REQ  = 2'b10;
        TGT1 = 4'd0;
        job("t4", -1, 1'b1, 1'b0);

        REQ  = 2'b01;
        TGT0 = 4'd9;
        job("t5", 4, 1'b0, 1'b0);
        REQ  = 2'b11;
        TGT0 = 4'd1;
        TGT1 = 4'd6;
        check("t5 tie_pick", pick(REQ), 1);
        job("t5b", -1, 1'b1, 1'b0);

        stuck = 1'b1;
        REQ   = 2'b01;
        TGT0  = 4'd4;
        got   = 1'b0;
        for (int n = 0; n < 10; n++) begin
            nedge;
            if (GNT != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check("t6 grant", GNT, 2'b01);
        last_w = 0;
`ifdef DCS_WATCHDOG_EN
        run = 0;
        got = 1'b0;
        err_n = 0;
        for (int n = 0; n < 40; n++) begin
            nedge;
            if (ERR) begin
                got = 1'b1;
                break;
            end
            if (DONE != 2'b00) err_n++;
            run++;
        end
        check("t6 err_seen", got, 1);
        check("t6 run_cycles", run, 8);
        check("t6 gnt", GNT, 0);
        check("t6 done", DONE, 0);
        check("t6 done_during", err_n, 0);
        REQ = 2'b00;
        nedge;
        check("t6 err_pulse", ERR, 0);
        check("t6 busy_end", BUSY, 0);
`else
        busy_n = 0;
        err_n = 0;
        for (int n = 0; n < 20; n++) begin
            nedge;
            busy_n += int'(BUSY);
            err_n += int'(ERR) + int'(DONE != 2'b00);
        end
        check("t6 busy_held", busy_n, 20);
        check("t6 no_err_done", err_n, 0);
        REQ = 2'b00;
        nedge;
        check("t6 busy_end", BUSY, 0);
`endif
        stuck = 1'b0;
        nedge;

        for (int i = 0; i < 30; i++) begin
            REQ  = 2'($urandom_range(1, 3));
            TGT0 = 4'($urandom);
            TGT1 = 4'($urandom);
            w = pick(REQ);
            tgt = (w == 1) ? int'(TGT1) : int'(TGT0);
            ab = -1;
            if (tgt > 0 && $urandom_range(0, 4) == 0)
                ab = $urandom_range(0, tgt - 1);
            job("rnd", ab, 1'b1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
